load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: validates width/alignment, drives a registered MMU
// port for one access at a time and returns extended load data or a fault.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        pipe_stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] mmu_addy,
  output logic [31:0] mmu_datain,
  output logic        mmu_wen,
  output logic        mmu_ren,
  output logic [3:0]  mmu_byte_select,
  input  logic        mmu_nostall,
  input  logic [31:0] mmu_dataout
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo;
  logic        is_store_q;
  logic [7:0]  wait_cnt;

  logic        illegal, misaligned;
  logic [3:0]  be;
  logic [31:0] wdat, shifted, load_ext;

  assign req_ready  = (state != ACCESS);
  assign pipe_stall = req_valid && !req_ready;

  // Request decode; BU/HU share the low funct3 bits with B/H.
  always_comb begin
    illegal    = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                 (req_funct3 == 3'b111) || (req_is_store && req_funct3[2]);
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    case (req_funct3[1:0])
      2'b00:   begin be = 4'b0001 << req_addr[1:0]; wdat = {4{req_wdata[7:0]}};  end
      2'b01:   begin be = 4'b0011 << req_addr[1:0]; wdat = {2{req_wdata[15:0]}}; end
      default: begin be = 4'b1111;                  wdat = req_wdata;            end
    endcase
  end

  always_comb begin
    shifted = mmu_dataout >> {addr_lo, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      funct3_q        <= 3'd0;
      addr_lo         <= 2'd0;
      is_store_q      <= 1'b0;
      wait_cnt        <= 8'd0;
      resp_valid      <= 1'b0;
      resp_rdata      <= 32'd0;
      fault           <= 1'b0;
      fault_cause     <= 2'b00;
      mmu_addy        <= 32'd0;
      mmu_datain      <= 32'd0;
      mmu_wen         <= 1'b0;
      mmu_ren         <= 1'b0;
      mmu_byte_select <= 4'd0;
    end else begin
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'd0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (req_valid) begin
            funct3_q   <= req_funct3;
            addr_lo    <= req_addr[1:0];
            is_store_q <= req_is_store;
            wait_cnt   <= 8'd0;
            if (illegal || misaligned) begin
              state       <= DONE;
              resp_valid  <= 1'b1;
              fault       <= 1'b1;
              fault_cause <= illegal ? 2'b10 : 2'b01;
            end else begin
              state           <= ACCESS;
              mmu_addy        <= {req_addr[31:2], 2'b00};
              mmu_datain      <= wdat;
              mmu_wen         <= req_is_store;
              mmu_ren         <= !req_is_store;
              mmu_byte_select <= be;
            end
          end
        end
        ACCESS: begin
          if (mmu_nostall || wait_cnt == 8'd254) begin
            state           <= DONE;
            resp_valid      <= 1'b1;
            mmu_wen         <= 1'b0;
            mmu_ren         <= 1'b0;
            mmu_byte_select <= 4'd0;
            if (mmu_nostall) begin
              resp_rdata <= is_store_q ? 32'd0 : load_ext;
            end else begin
              // 255th stalled edge: abandon the access.
              wait_cnt    <= wait_cnt + 8'd1;
              fault       <= 1'b1;
              fault_cause <= 2'b11;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
